// File: rtl/disp_pkg.sv
// Shared constants and types for the display-stream capture and analysis blocks.
package disp_pkg;
    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    localparam int ERR_HRES  = 0;
    localparam int ERR_VRES  = 1;
    localparam int ERR_LINE  = 2;
    localparam int ERR_DE_VS = 3;

    typedef enum logic {
        ST_SEEK    = 1'b0,
        ST_MEASURE = 1'b1
    } state_e;
endpackage

// File: rtl/crc16_par.sv
// Combinational CRC-16-CCITT update over a W-bit word, MSB first, no reflection.
module crc16_par
    import disp_pkg::*;
#(
    parameter int W = 15
) (
    input  logic [15:0]  crc_in,
    input  logic [W-1:0] data,
    output logic [15:0]  crc_out
);

    function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [W-1:0] d);
        logic [15:0] c;
        c = c_in;
        for (int i = W - 1; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    assign crc_out = crc_step(crc_in, data);

endmodule

// File: rtl/disp_frame_analyzer.sv
// Display-stream monitor: measures frame/line timing and a per-frame CRC of active
// pixels, reporting one result set per complete frame.
module disp_frame_analyzer
    import disp_pkg::*;
#(
    parameter int BPC      = 5,
    parameter int CORDW    = 16,
    parameter int EXP_H    = 640,
    parameter int EXP_V    = 480,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             disp_hsync,
    input  logic             disp_vsync,
    input  logic             disp_de,
    input  logic             disp_frame,
    input  logic [BPC-1:0]   disp_r,
    input  logic [BPC-1:0]   disp_g,
    input  logic [BPC-1:0]   disp_b,
    // meas_valid is a one-cycle strobe with no back-pressure; meas_* hold until the next strobe.
    output logic             meas_valid,
    output logic [CORDW-1:0] meas_hres,
    output logic [CORDW-1:0] meas_vres,
    output logic [CORDW-1:0] meas_htotal,
    output logic [CORDW-1:0] meas_hsw,
    output logic [15:0]      meas_crc,
    output logic [3:0]       meas_err,
    output logic [15:0]      frame_cnt,
    output state_e           dbg_state
);

    localparam int               PIXW    = 3 * BPC;
    localparam logic [CORDW-1:0] CNT_MAX = '1;
    localparam logic [CORDW-1:0] CNT_ONE = CORDW'(1);
    localparam logic [CORDW-1:0] EXP_H_C = CORDW'(EXP_H);
    localparam logic [CORDW-1:0] EXP_V_C = CORDW'(EXP_V);

    function automatic logic [CORDW-1:0] sat_inc(input logic [CORDW-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    state_e state_q, state_d;
    logic   commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_SEEK;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            ST_SEEK:    if (disp_frame) state_d = ST_MEASURE;
            ST_MEASURE: commit = disp_frame;
            default:    state_d = ST_SEEK;
        endcase
    end

    assign dbg_state = state_q;

    logic             hs_act, vs_act, hs_q, de_q;
    logic             hs_lead, hs_trail, lead_seen;
    logic [CORDW-1:0] hcyc, hsw_cnt, htotal_r, hsw_r;
    logic [CORDW-1:0] pix_cnt, line_cnt, hres_r;
    logic             hres_set, line_err, vs_err;
    logic [15:0]      crc_r, crc_seed, crc_nxt;
    logic [CORDW-1:0] fin_lines, fin_hres;
    logic             fin_line_err;
    logic [3:0]       fin_err;

    assign hs_act   = (disp_hsync == SYNC_POL);
    assign vs_act   = (disp_vsync == SYNC_POL);
    assign hs_lead  = hs_act & ~hs_q;
    assign hs_trail = ~hs_act & hs_q;

    // A frame boundary restarts the CRC from the seed so a de=1 pixel on that cycle lands in the new frame.
    assign crc_seed = disp_frame ? CRC16_INIT : crc_r;

    crc16_par #(.W(PIXW)) u_crc (
        .crc_in  (crc_seed),
        .data    ({disp_r, disp_g, disp_b}),
        .crc_out (crc_nxt)
    );

    // Values after closing any line still open (de_q=1); used on falling edges and at commit.
    assign fin_lines    = de_q ? sat_inc(line_cnt) : line_cnt;
    assign fin_hres     = (de_q && !hres_set) ? pix_cnt : hres_r;
    assign fin_line_err = line_err | (de_q & hres_set & (pix_cnt != hres_r));

    always_comb begin
        fin_err            = '0;
        fin_err[ERR_HRES]  = (fin_hres != EXP_H_C);
        fin_err[ERR_VRES]  = (fin_lines != EXP_V_C);
        fin_err[ERR_LINE]  = fin_line_err;
        fin_err[ERR_DE_VS] = vs_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q      <= 1'b0;
            lead_seen <= 1'b0;
            hcyc      <= '0;
            hsw_cnt   <= '0;
            htotal_r  <= '0;
            hsw_r     <= '0;
        end else begin
            hs_q <= hs_act;
            if (hs_lead) begin
                hcyc      <= CNT_ONE;
                lead_seen <= 1'b1;
                if (lead_seen) htotal_r <= hcyc;
            end else begin
                hcyc <= sat_inc(hcyc);
            end
            if (hs_act)   hsw_cnt <= hs_lead ? CNT_ONE : sat_inc(hsw_cnt);
            if (hs_trail) hsw_r   <= hsw_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q        <= 1'b0;
            pix_cnt     <= '0;
            line_cnt    <= '0;
            hres_r      <= '0;
            hres_set    <= 1'b0;
            line_err    <= 1'b0;
            vs_err      <= 1'b0;
            crc_r       <= CRC16_INIT;
            meas_valid  <= 1'b0;
            meas_hres   <= '0;
            meas_vres   <= '0;
            meas_htotal <= '0;
            meas_hsw    <= '0;
            meas_crc    <= '0;
            meas_err    <= '0;
            frame_cnt   <= '0;
        end else begin
            de_q       <= disp_de;
            meas_valid <= 1'b0;
            if (disp_frame) begin
                if (commit) begin
                    meas_valid  <= 1'b1;
                    meas_hres   <= fin_hres;
                    meas_vres   <= fin_lines;
                    meas_htotal <= htotal_r;
                    meas_hsw    <= hsw_r;
                    meas_crc    <= crc_r;
                    meas_err    <= fin_err;
                    frame_cnt   <= frame_cnt + 16'd1;
                end
                pix_cnt  <= disp_de ? CNT_ONE : '0;
                line_cnt <= '0;
                hres_r   <= '0;
                hres_set <= 1'b0;
                line_err <= 1'b0;
                vs_err   <= disp_de & vs_act;
                crc_r    <= disp_de ? crc_nxt : CRC16_INIT;
            end else if (state_q == ST_MEASURE) begin
                if (disp_de) begin
                    pix_cnt <= sat_inc(pix_cnt);
                    crc_r   <= crc_nxt;
                end else if (de_q) begin
                    line_cnt <= fin_lines;
                    hres_r   <= fin_hres;
                    hres_set <= 1'b1;
                    line_err <= fin_line_err;
                    pix_cnt  <= '0;
                end
                vs_err <= vs_err | (disp_de & vs_act);
            end
        end
    end

endmodule
